// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the multiplexed 7-segment refresh scheduler.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package seg_scan_pkg;

   // Scheduler phases: dark/idle, anti-ghosting gap, digit driven.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      ON    = 2'd2
   } scan_state_t;

   // Segment patterns {dp,g,f,e,d,c,b,a}, 1 = segment lit.
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_ALL   = 8'hFF;

   // Index width for n items; never narrower than one bit.
   function automatic int digit_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer: per-digit slot counter plus the PWM phase counter used during ON.
// Latency: flags are combinational from the counters; pwm_on previews the next ON cycle.
// Backpressure: none; counters free-run while run is high and clear otherwise.
module seg_slot_timer
   import seg_scan_pkg::*;
#(
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int BRIGHT_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    run,
   input  logic                    on_cur,
   input  logic                    on_nxt,
   input  logic [BRIGHT_WIDTH-1:0] bright,
   output logic                    blank_done,
   output logic                    slot_last,
   output logic                    pwm_on
);

   localparam int SLOT_W = digit_w(SLOT_CYCLES);

   logic [SLOT_W-1:0]       slot_cnt;
   logic [BRIGHT_WIDTH-1:0] pwm_cnt;
   logic [BRIGHT_WIDTH-1:0] pwm_nxt;

   assign blank_done = run && (slot_cnt == SLOT_W'(BLANK_CYCLES - 1));
   assign slot_last  = run && (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));

   // PWM phase for the coming cycle: zero on the first ON cycle, then counting.
   assign pwm_nxt = on_cur ? (pwm_cnt + BRIGHT_WIDTH'(1)) : '0;
   assign pwm_on  = (&bright) || (pwm_nxt < bright);

   // Slot counter spans BLANK + ON and restarts at every slot boundary or stop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_cnt <= '0;
      end else if (!run || slot_last) begin
         slot_cnt <= '0;
      end else begin
         slot_cnt <= slot_cnt + SLOT_W'(1);
      end
   end

   // PWM counter wraps freely inside ON and is held at zero elsewhere.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else if (on_nxt) begin
         pwm_cnt <= pwm_nxt;
      end else begin
         pwm_cnt <= '0;
      end
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment refresh scheduler with blank gaps, PWM and tear-free commit.
// Latency: all outputs registered; they reflect the state entered on the same edge.
// Backpressure: none; host writes and commits are always accepted.
module seg_scan_ctrl
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 2,
   parameter int SLOT_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int BRIGHT_WIDTH = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             enable,
   input  logic                             wr_en,
   input  logic [digit_w(NUM_DIGITS)-1:0]   wr_addr,
   input  logic [7:0]                       wr_data,
   input  logic [BRIGHT_WIDTH-1:0]          brightness,
   input  logic                             commit,
   output logic [7:0]                       led_pins,
   output logic [NUM_DIGITS-1:0]            led_sel_n,
   output logic                             frame_done,
   output logic                             commit_pending
);

   localparam int                 DIGIT_W    = digit_w(NUM_DIGITS);
   localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

   scan_state_t             state, state_nxt;
   logic [DIGIT_W-1:0]      digit, digit_nxt;
   logic [7:0]              shadow [NUM_DIGITS];
   logic [7:0]              active [NUM_DIGITS];
   logic [BRIGHT_WIDTH-1:0] active_bright;
   logic                    run, blank_done, slot_last, pwm_on;
   logic                    boundary, apply, lit_nxt;

   assign run = enable && (state != IDLE);

   seg_slot_timer #(
      .SLOT_CYCLES  (SLOT_CYCLES),
      .BLANK_CYCLES (BLANK_CYCLES),
      .BRIGHT_WIDTH (BRIGHT_WIDTH)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .on_cur     (state == ON),
      .on_nxt     (state_nxt == ON),
      .bright     (active_bright),
      .blank_done (blank_done),
      .slot_last  (slot_last),
      .pwm_on     (pwm_on)
   );

   // Frame ends on the last cycle of the last digit's slot; commits land there or in IDLE.
   assign boundary = (state == ON) && slot_last && (digit == LAST_DIGIT);
   assign apply    = commit_pending && (boundary || (state == IDLE));
   assign lit_nxt  = (state_nxt == ON) && pwm_on;

   // Next-state and digit sequencing; dropping enable forces IDLE from anywhere.
   always_comb begin
      state_nxt = state;
      digit_nxt = digit;
      if (!enable) begin
         state_nxt = IDLE;
         digit_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = BLANK;
               digit_nxt = '0;
            end
            BLANK: begin
               if (blank_done) state_nxt = ON;
            end
            ON: begin
               if (slot_last) begin
                  state_nxt = BLANK;
                  digit_nxt = (digit == LAST_DIGIT) ? '0 : digit + DIGIT_W'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               digit_nxt = '0;
            end
         endcase
      end
   end

   // State and digit index registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         digit <= '0;
      end else begin
         state <= state_nxt;
         digit <= digit_nxt;
      end
   end

   // Host shadow bank; out-of-range addresses are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= '0;
      end else if (wr_en && (int'(wr_addr) < NUM_DIGITS)) begin
         shadow[wr_addr] <= wr_data;
      end
   end

   // Active bank and brightness load from the shadow side only when a commit applies.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) active[i] <= '0;
         active_bright  <= '0;
         commit_pending <= 1'b0;
      end else begin
         if (apply) begin
            active        <= shadow;
            active_bright <= brightness;
         end
         // A commit arriving on the applying edge stays queued for the next frame.
         commit_pending <= commit || (commit_pending && !apply);
      end
   end

   // Pin drivers follow the state being entered so they change on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led_pins   <= '0;
         led_sel_n  <= '1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;
         if (lit_nxt) begin
            led_sel_n <= ~(NUM_DIGITS'(1) << digit_nxt);
            led_pins  <= active[digit_nxt];
         end else begin
            led_sel_n <= '1;
            led_pins  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 2-digit, 16-cycle slot, 2-cycle blank, 2-bit PWM setup.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
// Expected pin patterns come from hand-written PWM masks and frame arithmetic.
module tb_seg_scan_ctrl;

   localparam int ND = 2;
   localparam int SC = 16;
   localparam int BC = 2;
   localparam int BW = 2;

   logic          clk = 1'b0;
   logic          rst_n, enable, wr_en, commit;
   logic [0:0]    wr_addr;
   logic [7:0]    wr_data;
   logic [BW-1:0] brightness;
   logic [7:0]    led_pins;
   logic [ND-1:0] led_sel_n;
   logic          frame_done, commit_pending;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [1:0] br;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [3:0] mask;   // bit k = lit when pwm phase is k
   } vec_t;

   vec_t vecs [4];

   seg_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .SLOT_CYCLES  (SC),
      .BLANK_CYCLES (BC),
      .BRIGHT_WIDTH (BW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .brightness     (brightness),
      .commit         (commit),
      .led_pins       (led_pins),
      .led_sel_n      (led_sel_n),
      .frame_done     (frame_done),
      .commit_pending (commit_pending)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Expected {sel_n, pins} for sample n counted from the IDLE->BLANK edge.
   function automatic logic [9:0] exp_out(input int n, input logic [7:0] d0,
                                          input logic [7:0] d1, input logic [3:0] mask);
      int c;
      int dg;
      c  = n % SC;
      dg = (n / SC) % ND;
      if (c < BC || !mask[(c - BC) % 4]) return {2'b11, 8'h00};
      return (dg == 0) ? {2'b10, d0} : {2'b01, d1};
   endfunction

   task automatic chk_cyc(input string nm, input int n, input logic [7:0] d0,
                          input logic [7:0] d1, input logic [3:0] mask);
      chk($sformatf("%s[%0d]", nm, n), {22'b0, led_sel_n, led_pins},
          {22'b0, exp_out(n, d0, d1, mask)});
   endtask

   // Load both shadow digits and a brightness, commit while idle, confirm it applies.
   task automatic load(input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] br);
      wr_en = 1'b1; wr_addr = 1'b0; wr_data = d0;
      tick();
      wr_addr = 1'b1; wr_data = d1; brightness = br; commit = 1'b1;
      tick();
      wr_en = 1'b0; commit = 1'b0;
      chk("idle_pend_set", commit_pending, 1);
      tick();
      chk("idle_pend_apply", commit_pending, 0);
   endtask

   initial begin
      vecs[0] = '{br: 2'd3, d0: 8'h3F, d1: 8'h06, mask: 4'b1111};
      vecs[1] = '{br: 2'd1, d0: 8'h4F, d1: 8'h66, mask: 4'b0001};
      vecs[2] = '{br: 2'd2, d0: 8'h6D, d1: 8'h7D, mask: 4'b0011};
      vecs[3] = '{br: 2'd0, d0: 8'hFF, d1: 8'h07, mask: 4'b0000};

      rst_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_addr = 1'b0;
      wr_data = 8'h00; brightness = 2'd0; commit = 1'b0;
      tick();
      tick();
      chk("reset_out", {20'b0, frame_done, commit_pending, led_sel_n, led_pins}, 32'h300);
      rst_n = 1'b1;

      // Held disabled: dark, no frame pulses.
      for (int i = 0; i < 40; i++) begin
         tick();
         chk($sformatf("idle_hold[%0d]", i),
             {20'b0, frame_done, commit_pending, led_sel_n, led_pins}, 32'h300);
      end

      // Table: brightness/pattern pairs over two full frames each.
      for (int v = 0; v < 4; v++) begin
         load(vecs[v].d0, vecs[v].d1, vecs[v].br);
         enable = 1'b1;
         for (int n = 0; n <= 64; n++) begin
            tick();
            chk_cyc($sformatf("vec%0d_out", v), n, vecs[v].d0, vecs[v].d1, vecs[v].mask);
            chk($sformatf("vec%0d_fd[%0d]", v, n), frame_done, (n > 0 && n % 32 == 0));
            chk($sformatf("vec%0d_pend[%0d]", v, n), commit_pending, 0);
         end
         enable = 1'b0;
         tick();
         chk($sformatf("vec%0d_off", v), {22'b0, led_sel_n, led_pins}, 32'h300);
      end

      // Mid-frame write + commit: old pattern holds until the frame boundary.
      load(8'h3F, 8'h06, 2'd3);
      enable = 1'b1;
      for (int n = 0; n <= 65; n++) begin
         tick();
         chk_cyc("mid_out", n, (n < 32) ? 8'h3F : 8'h5B, 8'h06, 4'b1111);
         chk($sformatf("mid_pend[%0d]", n), commit_pending, (n >= 6 && n < 32));
         chk($sformatf("mid_fd[%0d]", n), frame_done, (n > 0 && n % 32 == 0));
         if (n == 5) begin
            wr_en = 1'b1; wr_addr = 1'b0; wr_data = 8'h5B; commit = 1'b1;
         end
         if (n == 6) begin
            wr_en = 1'b0; commit = 1'b0;
         end
      end
      enable = 1'b0;
      tick();

      // Write + commit in the boundary cycle: lands one frame later.
      enable = 1'b1;
      for (int n = 0; n <= 80; n++) begin
         tick();
         chk_cyc("bnd_out", n, (n < 64) ? 8'h5B : 8'h66, 8'h06, 4'b1111);
         chk($sformatf("bnd_pend[%0d]", n), commit_pending, (n >= 32 && n < 64));
         chk($sformatf("bnd_fd[%0d]", n), frame_done, (n > 0 && n % 32 == 0));
         if (n == 31) begin
            wr_en = 1'b1; wr_addr = 1'b0; wr_data = 8'h66; commit = 1'b1;
         end
         if (n == 32) begin
            wr_en = 1'b0; commit = 1'b0;
         end
      end
      enable = 1'b0;
      tick();

      // Enable dropped mid-ON, then re-enabled from digit 0.
      enable = 1'b1;
      for (int n = 0; n <= 7; n++) begin
         tick();
         chk_cyc("drop_out", n, 8'h66, 8'h06, 4'b1111);
      end
      enable = 1'b0;
      tick();
      chk("drop_dark", {22'b0, led_sel_n, led_pins}, 32'h300);
      enable = 1'b1;
      for (int n = 0; n <= 20; n++) begin
         tick();
         chk_cyc("reen_out", n, 8'h66, 8'h06, 4'b1111);
         if (n == 19) commit = 1'b1;
         if (n == 20) chk("reen_pend", commit_pending, 1);
      end

      // Reset mid-frame with a pending commit: everything back to reset values.
      rst_n = 1'b0; enable = 1'b0; commit = 1'b0;
      tick();
      chk("midrst_out", {20'b0, frame_done, commit_pending, led_sel_n, led_pins}, 32'h300);
      rst_n = 1'b1;

      // Shadow bank was cleared by reset: full brightness shows a blank pattern.
      brightness = 2'd3; commit = 1'b1;
      tick();
      commit = 1'b0;
      tick();
      enable = 1'b1;
      for (int n = 0; n <= 17; n++) begin
         tick();
         chk_cyc("postrst_out", n, 8'h00, 8'h00, 4'b1111);
      end
      enable = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
